// File: rtl/if_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// if_stage_pkg : bus widths, fetch FSM encodings and bus structs (rev 1.0)
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 33;

  localparam logic [1:0] FS_STATE_REQ  = 2'd0;
  localparam logic [1:0] FS_STATE_DATA = 2'd1;
  localparam logic [1:0] FS_STATE_HOLD = 2'd2;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage
`default_nettype wire

// File: rtl/if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// if_stage : LoongArch fetch stage, one outstanding SRAM request (rev 1.0)
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] fs_inst_q, fs_inst_d;
  logic        cancel_q, cancel_d;

  br_bus_t   br;
  fs_to_ds_t ds_bus;
  logic      redirect;

  assign br       = br_bus;
  // Decode only releases a branch when it can hand it on, so this fires once per branch.
  assign redirect = br.taken & ds_allowin;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fs_pc_d    = fs_pc_q;
    fs_inst_d  = fs_inst_q;
    cancel_d   = cancel_q;
    case (state_q)
      FS_STATE_REQ: begin
        if (inst_sram_addr_ok) begin
          fs_pc_d = fetch_pc_q;
          state_d = FS_STATE_DATA;
        end
        if (redirect) begin
          fetch_pc_d = br.target;
          cancel_d   = inst_sram_addr_ok;
        end
      end
      FS_STATE_DATA: begin
        if (redirect) begin
          fetch_pc_d = br.target;
          if (inst_sram_data_ok) begin
            cancel_d = 1'b0;
            state_d  = FS_STATE_REQ;
          end else begin
            cancel_d = 1'b1;
          end
        end else if (inst_sram_data_ok) begin
          if (cancel_q) begin
            cancel_d = 1'b0;
            state_d  = FS_STATE_REQ;
          end else begin
            fs_inst_d = inst_sram_rdata;
            state_d   = FS_STATE_HOLD;
          end
        end
      end
      FS_STATE_HOLD: begin
        if (redirect) begin
          fetch_pc_d = br.target;
          state_d    = FS_STATE_REQ;
        end else if (ds_allowin) begin
          fetch_pc_d = fs_pc_q + 32'd4;
          state_d    = FS_STATE_REQ;
        end
      end
      default: state_d = FS_STATE_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FS_STATE_REQ;
      fetch_pc_q <= RESET_PC;
      fs_pc_q    <= 32'd0;
      fs_inst_q  <= 32'd0;
      cancel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fs_pc_q    <= fs_pc_d;
      fs_inst_q  <= fs_inst_d;
      cancel_q   <= cancel_d;
    end
  end

  assign inst_sram_req  = resetn & (state_q == FS_STATE_REQ);
  assign inst_sram_addr = fetch_pc_q;

  // A redirect in HOLD squashes the held wrong-path instruction in the same cycle.
  assign fs_to_ds_valid = (state_q == FS_STATE_HOLD) & ~redirect;
  assign ds_bus.inst    = fs_inst_q;
  assign ds_bus.pc      = fs_pc_q;
  assign fs_to_ds_bus   = ds_bus;

`ifndef SYNTHESIS
  // A response from a request aborted by reset may still land before the first new accept.
  logic stale_ok_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stale_ok_q <= 1'b1;
    end else if (inst_sram_req && inst_sram_addr_ok) begin
      stale_ok_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(inst_sram_data_ok && state_q == FS_STATE_REQ && !stale_ok_q))
        else $error("if_stage: data_ok with no request outstanding");
      assert (!(inst_sram_addr_ok && state_q != FS_STATE_REQ))
        else $error("if_stage: addr_ok while no request is driven");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_stage : directed checks of fetch sequencing, stalls, redirects, reset
// ---------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_bus = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        addr_ok_en = 1'b0;
  logic        auto_mode = 1'b1;
  logic        man_dok = 1'b0;
  logic        auto_dok = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  int total = 0;
  int bad = 0;

  function automatic logic [31:0] winst(input logic [31:0] a);
    return a ^ 32'hFFFF0000;
  endfunction

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ds_allowin       (ds_allowin),
    .br_bus           (br_bus),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Memory: accepts whenever enabled, answers the following cycle unless in manual mode.
  assign inst_sram_addr_ok = inst_sram_req & addr_ok_en;
  assign inst_sram_data_ok = auto_mode ? auto_dok : man_dok;
  assign inst_sram_rdata   = winst(pend_addr);

  always @(posedge clk) begin
    auto_dok <= inst_sram_req & inst_sram_addr_ok;
    if (inst_sram_req && inst_sram_addr_ok) pend_addr <= inst_sram_addr;
  end

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", inst_sram_req); end
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", fs_to_ds_valid); end
    total++; if (fs_to_ds_bus !== 64'd0) begin bad++; $display("FAIL rst_bus: got %h want 0", fs_to_ds_bus); end
    total++; if (inst_sram_addr !== RST_PC) begin bad++; $display("FAIL rst_addr: got %h want %h", inst_sram_addr, RST_PC); end
  endtask

  task automatic test_sequential;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b1;
    resetn = 1'b1;
    #1;
    total++; if (inst_sram_req !== 1'b1) begin bad++; $display("FAIL seq_req0: got %b want 1", inst_sram_req); end
    total++; if (inst_sram_addr !== RST_PC) begin bad++; $display("FAIL seq_addr0: got %h want %h", inst_sram_addr, RST_PC); end
    @(negedge clk);
    total++; if ({fs_to_ds_valid, inst_sram_req} !== 2'b00) begin bad++; $display("FAIL seq_data_phase: got valid/req %b want 00", {fs_to_ds_valid, inst_sram_req}); end
    @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL seq_valid0: got %b want 1", fs_to_ds_valid); end
    total++; if (fs_to_ds_bus !== {winst(RST_PC), RST_PC}) begin bad++; $display("FAIL seq_bus0: got %h want %h", fs_to_ds_bus, {winst(RST_PC), RST_PC}); end
    @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL seq_valid_gap: got %b want 0", fs_to_ds_valid); end
    total++; if (inst_sram_addr !== 32'h1c000004 || inst_sram_req !== 1'b1) begin bad++; $display("FAIL seq_addr1: got req %b addr %h want 1 1c000004", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    ds_allowin = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++; if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, fs_to_ds_valid); end
      total++; if (fs_to_ds_bus !== {winst(32'h1c000004), 32'h1c000004}) begin bad++; $display("FAIL stall_bus[%0d]: got %h", i, fs_to_ds_bus); end
      total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d]: got %b want 0", i, inst_sram_req); end
      if (i < 4) @(negedge clk);
    end
    ds_allowin = 1'b1;
    @(negedge clk);
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000008) begin bad++; $display("FAIL stall_next_addr: got req %b addr %h want 1 1c000008", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_redirect_hold;
    repeat (2) @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[31:0] !== 32'h1c000008) begin bad++; $display("FAIL rh_held: got valid %b pc %h want 1 1c000008", fs_to_ds_valid, fs_to_ds_bus[31:0]); end
    br_bus = {1'b1, 32'h1c000040};
    #1;
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rh_squash: got %b want 0", fs_to_ds_valid); end
    @(negedge clk);
    br_bus = '0;
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000040) begin bad++; $display("FAIL rh_req_addr: got req %b addr %h want 1 1c000040", inst_sram_req, inst_sram_addr); end
    repeat (2) @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {winst(32'h1c000040), 32'h1c000040}) begin bad++; $display("FAIL rh_deliver: got valid %b bus %h", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_redirect_data;
    @(negedge clk);
    total++; if (inst_sram_addr !== 32'h1c000044) begin bad++; $display("FAIL rd_addr_seq: got %h want 1c000044", inst_sram_addr); end
    auto_mode = 1'b0;
    man_dok = 1'b0;
    @(negedge clk);
    total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL rd_in_data: got req %b want 0", inst_sram_req); end
    br_bus = {1'b1, 32'h1c000100};
    #1;
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_a: got %b want 0", fs_to_ds_valid); end
    @(negedge clk);
    br_bus = '0;
    total++; if ({fs_to_ds_valid, inst_sram_req} !== 2'b00) begin bad++; $display("FAIL rd_wait_data: got valid/req %b want 00", {fs_to_ds_valid, inst_sram_req}); end
    man_dok = 1'b1;
    @(negedge clk);
    man_dok = 1'b0;
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rd_dropped: got valid %b want 0", fs_to_ds_valid); end
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin bad++; $display("FAIL rd_target_req: got req %b addr %h want 1 1c000100", inst_sram_req, inst_sram_addr); end
    auto_mode = 1'b1;
    @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_b: got %b want 0", fs_to_ds_valid); end
    @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {winst(32'h1c000100), 32'h1c000100}) begin bad++; $display("FAIL rd_deliver: got valid %b bus %h", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_redirect_req;
    addr_ok_en = 1'b0;
    @(negedge clk);
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000104) begin bad++; $display("FAIL rq_seq: got req %b addr %h want 1 1c000104", inst_sram_req, inst_sram_addr); end
    br_bus = {1'b1, 32'h1c000200};
    @(negedge clk);
    br_bus = '0;
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin bad++; $display("FAIL rq_switch: got req %b addr %h want 1 1c000200", inst_sram_req, inst_sram_addr); end
    @(negedge clk);
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin bad++; $display("FAIL rq_hold_addr: got req %b addr %h want 1 1c000200", inst_sram_req, inst_sram_addr); end
    addr_ok_en = 1'b1;
    @(negedge clk);
    total++; if ({fs_to_ds_valid, inst_sram_req} !== 2'b00) begin bad++; $display("FAIL rq_data_phase: got valid/req %b want 00", {fs_to_ds_valid, inst_sram_req}); end
    @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {winst(32'h1c000200), 32'h1c000200}) begin bad++; $display("FAIL rq_deliver: got valid %b bus %h", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000204) begin bad++; $display("FAIL rm_seq: got req %b addr %h want 1 1c000204", inst_sram_req, inst_sram_addr); end
    auto_mode = 1'b0;
    man_dok = 1'b0;
    @(negedge clk);
    total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL rm_in_data: got req %b want 0", inst_sram_req); end
    resetn = 1'b0;
    #1;
    total++; if ({inst_sram_req, fs_to_ds_valid} !== 2'b00 || fs_to_ds_bus !== 64'd0) begin bad++; $display("FAIL rm_async: got req/valid %b bus %h", {inst_sram_req, fs_to_ds_valid}, fs_to_ds_bus); end
    total++; if (inst_sram_addr !== RST_PC) begin bad++; $display("FAIL rm_addr_rst: got %h want %h", inst_sram_addr, RST_PC); end
    @(negedge clk);
    resetn = 1'b1;
    addr_ok_en = 1'b0;
    man_dok = 1'b1;
    @(negedge clk);
    man_dok = 1'b0;
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rm_late_ignored: got valid %b want 0", fs_to_ds_valid); end
    total++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin bad++; $display("FAIL rm_restart: got req %b addr %h want 1 %h", inst_sram_req, inst_sram_addr, RST_PC); end
    addr_ok_en = 1'b1;
    auto_mode = 1'b1;
    @(negedge clk);
    total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL rm_accept: got req %b want 0", inst_sram_req); end
    @(negedge clk);
    total++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {winst(RST_PC), RST_PC}) begin bad++; $display("FAIL rm_deliver: got valid %b bus %h", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_hold();
    test_redirect_data();
    test_redirect_req();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
